// File: rtl/reg_bank_mp.sv
// Multi-port register bank: DEPTH x WIDTH storage, one synchronous write port,
// NUM_RD combinational read ports, hardwired-zero entry 0, optional write bypass.
`timescale 1ns/1ps
module reg_bank_mp #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we,
    input  logic [ADDR_W-1:0]              waddr,
    input  logic [WIDTH-1:0]               wdata,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  raddr,
    output logic [NUM_RD-1:0][WIDTH-1:0]   rdata,
    output logic [15:0]                    wr_cnt
);

    localparam bit POW2 = (DEPTH == (1 << ADDR_W));

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              w_in_range;
    logic [NUM_RD-1:0] r_in_range;
    logic              wr_ok;

    // A power-of-two depth has no unreachable addresses, so the range test folds away.
    generate
        if (POW2) begin : g_pow2
            assign w_in_range = 1'b1;
            assign r_in_range = '1;
        end else begin : g_npow2
            localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
            assign w_in_range = ({1'b0, waddr} < DEPTH_L);
            for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
                assign r_in_range[i] = ({1'b0, raddr[i]} < DEPTH_L);
            end
        end
    endgenerate

    assign wr_ok = we && (waddr != '0) && w_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_cnt <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
            wr_cnt     <= wr_cnt + 16'd1;
        end
    end

    // Reads are gated by rst_n so a bypassed wdata cannot leak out during reset.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rst_n && (raddr[i] != '0) && r_in_range[i]) begin
                if ((BYPASS != 0) && wr_ok && (raddr[i] == waddr))
                    rdata[i] = wdata;
                else
                    rdata[i] = mem[raddr[i]];
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Scoreboard bench for reg_bank_mp: a 32-deep 2-port bypassing bank and a
// 24-deep 3-port non-bypassing bank share one write port.
`timescale 1ns/1ps
module tb_reg_bank_mp;

    logic            clk, rst_n, we;
    logic [4:0]      waddr;
    logic [31:0]     wdata;
    logic [1:0][4:0] raddr_a;
    logic [1:0][31:0] rdata_a;
    logic [15:0]     wr_cnt_a;
    logic [2:0][4:0] raddr_b;
    logic [2:0][31:0] rdata_b;
    logic [15:0]     wr_cnt_b;

    reg_bank_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr_a), .rdata(rdata_a), .wr_cnt(wr_cnt_a)
    );

    reg_bank_mp #(.WIDTH(32), .DEPTH(24), .NUM_RD(3), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr_b), .rdata(rdata_b), .wr_cnt(wr_cnt_b)
    );

    typedef struct {
        int          dut;
        bit          is_cnt;
        logic [1:0]  port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] mdl_a [32];
    logic [31:0] mdl_b [24];
    logic [15:0] cnt_a, cnt_b;
    event        sample_ev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] actual(exp_t e);
        if (e.dut == 0)
            return e.is_cnt ? {16'h0, wr_cnt_a} : rdata_a[e.port[0]];
        return e.is_cnt ? {16'h0, wr_cnt_b} : rdata_b[e.port];
    endfunction

    // Monitor: drains every pending expectation on the falling edge or on demand.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk or sample_ev);
            while (sb.size() > 0) begin
                e   = sb.pop_front();
                act = actual(e);
                checks++;
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s dut=%0d cnt=%0d port=%0d actual=%h required=%h",
                             e.name, e.dut, e.is_cnt, e.port, act, e.exp);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    task automatic push(int dut, bit is_cnt, logic [1:0] port, logic [31:0] exp, string name);
        exp_t e;
        e.dut = dut; e.is_cnt = is_cnt; e.port = port; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic push_rd(logic [31:0] a0, logic [31:0] a1, logic [31:0] b0,
                           logic [31:0] b1, logic [31:0] b2, string name);
        push(0, 0, 2'd0, a0, name); push(0, 0, 2'd1, a1, name);
        push(1, 0, 2'd0, b0, name); push(1, 0, 2'd1, b1, name); push(1, 0, 2'd2, b2, name);
    endtask

    task automatic push_cnt(logic [15:0] ca, logic [15:0] cb, string name);
        push(0, 1, 2'd0, {16'h0, ca}, name);
        push(1, 1, 2'd0, {16'h0, cb}, name);
    endtask

    task automatic clear_model();
        mdl_a = '{default: '0};
        mdl_b = '{default: '0};
        cnt_a = '0;
        cnt_b = '0;
    endtask

    task automatic model_commit(logic [4:0] a, logic [31:0] d);
        if (a != 5'd0) begin
            mdl_a[a] = d;
            cnt_a++;
        end
        if (a != 5'd0 && a < 5'd24) begin
            mdl_b[a] = d;
            cnt_b++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [4:0] a, logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
        model_commit(a, d);
    endtask

    // Mid-cycle 3ns reset pulse: outputs checked while low and after release.
    task automatic reset_pulse(string name);
        rst_n = 1'b0;
        #1;
        push_rd('0, '0, '0, '0, '0, {name, "_low"});
        push_cnt(16'd0, 16'd0, {name, "_low_cnt"});
        ->sample_ev;
        #2;
        rst_n = 1'b1;
        clear_model();
        push_rd('0, '0, '0, '0, '0, {name, "_rel"});
        push_cnt(16'd0, 16'd0, {name, "_rel_cnt"});
        step();
    endtask

    function automatic logic [31:0] exp_a(logic [4:0] ra);
        if (we && ra == waddr && ra != 5'd0) return wdata;
        return mdl_a[ra];
    endfunction

    function automatic logic [31:0] exp_b(logic [4:0] ra);
        if (ra == 5'd0 || ra >= 5'd24) return '0;
        return mdl_b[ra];
    endfunction

    task automatic random_phase(int n);
        for (int c = 0; c < n; c++) begin
            we    = 1'($urandom_range(0, 1));
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            for (int p = 0; p < 2; p++)
                raddr_a[p] = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            for (int p = 0; p < 3; p++)
                raddr_b[p] = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            push_rd(exp_a(raddr_a[0]), exp_a(raddr_a[1]),
                    exp_b(raddr_b[0]), exp_b(raddr_b[1]), exp_b(raddr_b[2]), "random_rd");
            push_cnt(cnt_a, cnt_b, "random_cnt");
            step();
            if (we) model_commit(waddr, wdata);
        end
        we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0;
        clear_model();
        #1 rst_n = 1'b0;
        raddr_a[0] = 5'd1; raddr_a[1] = 5'd3;
        raddr_b[0] = 5'd1; raddr_b[1] = 5'd2; raddr_b[2] = 5'd0;
        push_rd('0, '0, '0, '0, '0, "reset_init");
        push_cnt(16'd0, 16'd0, "reset_init_cnt");
        @(negedge clk);
        #2 rst_n = 1'b1;
        step();

        // Fill entries 1..31, then reset mid-cycle
        for (int i = 1; i < 32; i++)
            wr(5'(i), 32'h1000_0000 | (32'(i) * 32'h0101));
        raddr_a[0] = 5'd31; raddr_a[1] = 5'd1;
        raddr_b[0] = 5'd23; raddr_b[1] = 5'd24; raddr_b[2] = 5'd1;
        push_rd(32'h1000_1F1F, 32'h1000_0101, 32'h1000_1717, 32'h0, 32'h1000_0101, "fill");
        push_cnt(16'd31, 16'd23, "fill_cnt");
        step();
        reset_pulse("reset_mid");

        // Write then read on both ports
        wr(5'd5, 32'hDEADBEEF);
        raddr_a[0] = 5'd5; raddr_a[1] = 5'd5;
        raddr_b[0] = 5'd5; raddr_b[1] = 5'd0; raddr_b[2] = 5'd5;
        push_rd(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, "wr_rd");
        push_cnt(16'd1, 16'd1, "wr_rd_cnt");
        step();

        // Entry 0 ignores writes and never bypasses
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        raddr_a[0] = 5'd0; raddr_b[1] = 5'd0;
        push_rd(32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, "zero_same_cycle");
        step();
        we = 1'b0;
        push_rd(32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, "zero_after");
        push_cnt(16'd1, 16'd1, "zero_cnt");
        step();

        // Bypass on dut_a, stored value on dut_b, unrelated port untouched
        wr(5'd7, 32'h1111_1111);
        we = 1'b1; waddr = 5'd7; wdata = 32'h2222_2222;
        raddr_a[0] = 5'd5; raddr_a[1] = 5'd7;
        raddr_b[0] = 5'd5; raddr_b[1] = 5'd7; raddr_b[2] = 5'd7;
        push_rd(32'hDEADBEEF, 32'h2222_2222, 32'hDEADBEEF, 32'h1111_1111, 32'h1111_1111, "bypass");
        push_cnt(16'd2, 16'd2, "bypass_cnt");
        step();
        we = 1'b0;
        model_commit(5'd7, 32'h2222_2222);
        push_rd(32'hDEADBEEF, 32'h2222_2222, 32'hDEADBEEF, 32'h2222_2222, 32'h2222_2222, "bypass_after");
        push_cnt(16'd3, 16'd3, "bypass_after_cnt");
        step();

        // Out-of-range address on the 24-deep bank
        wr(5'd23, 32'h0000_00A5);
        wr(5'd27, 32'h0000_00A5);
        raddr_a[0] = 5'd27; raddr_a[1] = 5'd23;
        raddr_b[0] = 5'd23; raddr_b[1] = 5'd27; raddr_b[2] = 5'd5;
        push_rd(32'hA5, 32'hA5, 32'hA5, 32'h0, 32'hDEADBEEF, "range");
        push_cnt(16'd5, 16'd4, "range_cnt");
        step();

        // Counter wrap after 65536 valid writes from reset
        reset_pulse("reset_wrap");
        for (int i = 0; i < 65535; i++)
            wr(5'((i % 31) + 1), 32'(i));
        push(0, 1, 2'd0, 32'h0000_FFFF, "wrap_ffff");
        step();
        wr(5'd1, 32'h0BAD_F00D);
        push(0, 1, 2'd0, 32'h0000_0000, "wrap_zero");
        push(1, 1, 2'd0, {16'h0, cnt_b}, "wrap_cnt_b");
        raddr_a[0] = 5'd1; raddr_b[0] = 5'd1;
        push(0, 0, 2'd0, 32'h0BAD_F00D, "wrap_rd_a");
        push(1, 0, 2'd0, 32'h0BAD_F00D, "wrap_rd_b");
        step();

        random_phase(10000);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
